// File: rtl/arbitro_rr_4x4.sv
// Four-input to four-output word arbiter: pops show-ahead input FIFOs and
// pushes each word to the output FIFO selected by its destination field.
module arbitro_rr_4x4 #(
  parameter int DATA_WIDTH = 8,
  parameter int DEST_WIDTH = 4,
  parameter int PRIO_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [3:0]            empty_in,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic [DEST_WIDTH-1:0] dest_in0,
  input  logic [DEST_WIDTH-1:0] dest_in1,
  input  logic [DEST_WIDTH-1:0] dest_in2,
  input  logic [DEST_WIDTH-1:0] dest_in3,
  input  logic [3:0]            afull_out,
  output logic [3:0]            pop_in,
  output logic [3:0]            push_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  active,
  output logic [7:0]            drop_cnt
);

  typedef enum logic {IDLE = 1'b0, ARB = 1'b1} state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

  state_t                state_q, state_d;
  logic [1:0]            rr_ptr_q;
  logic [3:0]            push_q, push_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DEST_WIDTH-1:0] dest_q;
  logic [7:0]            drop_q;

  logic [DATA_WIDTH-1:0] data_a [4];
  logic [DEST_WIDTH-1:0] dest_a [4];
  logic [3:0]            routable_s;
  logic [3:0]            elig_s;
  logic [1:0]            gidx_s;
  logic [1:0]            scan_s;
  logic                  go_s;

  assign data_a[0] = data_in0;
  assign data_a[1] = data_in1;
  assign data_a[2] = data_in2;
  assign data_a[3] = data_in3;
  assign dest_a[0] = dest_in0;
  assign dest_a[1] = dest_in1;
  assign dest_a[2] = dest_in2;
  assign dest_a[3] = dest_in3;

  // Unroutable words ignore back-pressure: they are popped and dropped.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      routable_s[i] = (dest_a[i] <= DEST_WIDTH'(3));
      elig_s[i]     = ~empty_in[i] & (~routable_s[i] | ~afull_out[dest_a[i][1:0]]);
    end
  end

  // Winner selection; descending scan lets the nearest candidate overwrite.
  always_comb begin
    gidx_s = 2'd0;
    scan_s = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (PRIO_MODE != 0) begin
        scan_s = 2'(k);
      end else begin
        scan_s = rr_ptr_q + 2'(k);
      end
      if (elig_s[scan_s]) begin
        gidx_s = scan_s;
      end else begin
        gidx_s = gidx_s;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable && (|elig_s)) begin
          state_d = ARB;
        end else begin
          state_d = IDLE;
        end
      end
      ARB: begin
        if (!enable || !(|elig_s)) begin
          state_d = IDLE;
        end else begin
          state_d = ARB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    go_s   = (state_d == ARB);
    pop_in = 4'b0000;
    push_d = 4'b0000;
    if (go_s && !reset) begin
      pop_in = onehot4(gidx_s);
    end else begin
      pop_in = 4'b0000;
    end
    if (go_s && routable_s[gidx_s]) begin
      push_d = onehot4(dest_a[gidx_s][1:0]);
    end else begin
      push_d = 4'b0000;
    end
  end

  // Push stage: registered one cycle after the grant; data holds when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= 2'd0;
      push_q   <= 4'b0000;
      data_q   <= '0;
      dest_q   <= '0;
      drop_q   <= 8'd0;
    end else begin
      push_q <= push_d;
      if (go_s) begin
        rr_ptr_q <= gidx_s + 2'd1;
        if (routable_s[gidx_s]) begin
          data_q <= data_a[gidx_s];
          dest_q <= dest_a[gidx_s];
        end else begin
          drop_q <= drop_q + 8'd1;
        end
      end
    end
  end

  assign push_out = push_q;
  assign data_out = data_q;
  assign dest_out = dest_q;
  assign active   = (state_q == ARB);
  assign drop_cnt = drop_q;

endmodule
